// File: rtl/dispatch_ctrl_if.sv
// Shared decode bundle type and the decode/back-end handshake interface
// seen by the dispatch controller.
package dispatch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  ALUOp;
        logic [6:0]  Opcode;
    } decode_data;

    localparam logic [1:0] FU_ALU = 2'b00;
    localparam logic [1:0] FU_LSU = 2'b01;
    localparam logic [1:0] FU_BR  = 2'b10;
    localparam logic [1:0] FU_ILL = 2'b11;
endpackage

interface dispatch_ctrl_if #(
    parameter int ROB_IDX_W = 4,
    parameter int STALL_W   = 16
) ();
    import dispatch_pkg::*;

    logic                 dec_valid;
    logic                 dec_ready;
    decode_data           dec_data;
    logic                 flush;
    logic                 rob_ready;
    logic                 rs_alu_ready;
    logic                 rs_lsu_ready;
    logic                 rs_br_ready;
    logic                 fl_empty;
    logic                 disp_valid;
    decode_data           disp_data;
    logic [1:0]           disp_fu;
    logic [ROB_IDX_W-1:0] disp_tag;
    logic                 alu_we;
    logic                 lsu_we;
    logic                 br_we;
    logic                 fl_pop;
    logic                 illegal_op;
    logic [STALL_W-1:0]   stall_cycles;

    modport master (
        output dec_valid, dec_data, flush, rob_ready,
        output rs_alu_ready, rs_lsu_ready, rs_br_ready, fl_empty,
        input  dec_ready, disp_valid, disp_data, disp_fu, disp_tag,
        input  alu_we, lsu_we, br_we, fl_pop, illegal_op, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_data, flush, rob_ready,
        input  rs_alu_ready, rs_lsu_ready, rs_br_ready, fl_empty,
        output dec_ready, disp_valid, disp_data, disp_fu, disp_tag,
        output alu_we, lsu_we, br_we, fl_pop, illegal_op, stall_cycles
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: 2-entry decode FIFO, opcode classification,
// resource-gated single-issue dispatch, ROB tagging and stall counting.
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int ROB_IDX_W = 4,
    parameter int STALL_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    dispatch_ctrl_if.slave  bus
);

    decode_data           r_mem [2];
    logic                 r_head;
    logic                 r_tail;
    logic [1:0]           r_count;
    logic [ROB_IDX_W-1:0] r_tag;
    logic [STALL_W-1:0]   r_stall;

    decode_data w_head;
    logic       w_hvalid;
    logic [1:0] w_fu;
    logic       w_legal;
    logic       w_need_preg;
    logic       w_rs_rdy;
    logic       w_fire;
    logic       w_drop;
    logic       w_deq;
    logic       w_enq;
    logic       w_dec_ready;

    assign w_head   = r_mem[r_head];
    assign w_hvalid = (r_count != 2'd0);

    always_comb begin
        w_fu = FU_ILL;
        case (w_head.Opcode)
            7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111: w_fu = FU_ALU;
            7'b0000011, 7'b0100011: w_fu = FU_LSU;
            7'b1100011, 7'b1101111,
            7'b1100111:             w_fu = FU_BR;
            default:                w_fu = FU_ILL;
        endcase
    end

    always_comb begin
        w_rs_rdy = 1'b0;
        case (w_fu)
            FU_ALU:  w_rs_rdy = bus.rs_alu_ready;
            FU_LSU:  w_rs_rdy = bus.rs_lsu_ready;
            FU_BR:   w_rs_rdy = bus.rs_br_ready;
            default: w_rs_rdy = 1'b0;
        endcase
    end

    // Stores and conditional branches never write a destination register
    assign w_legal     = (w_fu != FU_ILL);
    assign w_need_preg = (w_head.rd != 5'd0)
                       && (w_head.Opcode != 7'b0100011)
                       && (w_head.Opcode != 7'b1100011);

    assign w_fire = w_hvalid && !bus.flush && w_legal
                  && bus.rob_ready && w_rs_rdy
                  && (!w_need_preg || !bus.fl_empty);
    assign w_drop = w_hvalid && !bus.flush && !w_legal;
    assign w_deq  = w_fire || w_drop;

    assign w_dec_ready = (r_count != 2'd2) && !bus.flush;
    assign w_enq       = bus.dec_valid && w_dec_ready;

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= bus.dec_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else if (bus.flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_tail <= ~r_tail;
            if (w_deq) r_head <= ~r_head;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag   <= '0;
            r_stall <= '0;
        end else begin
            if (w_fire) r_tag <= r_tag + 1'b1;
            if (w_hvalid && w_legal && !bus.flush && !w_fire
                && (r_stall != '1))
                r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.dec_ready    = w_dec_ready;
    assign bus.disp_valid   = w_fire;
    assign bus.disp_data    = w_head;
    assign bus.disp_fu      = w_fu;
    assign bus.disp_tag     = r_tag;
    assign bus.alu_we       = w_fire && (w_fu == FU_ALU);
    assign bus.lsu_we       = w_fire && (w_fu == FU_LSU);
    assign bus.br_we        = w_fire && (w_fu == FU_BR);
    assign bus.fl_pop       = w_fire && w_need_preg;
    assign bus.illegal_op   = w_drop;
    assign bus.stall_cycles = r_stall;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: dispatch, backpressure, flush,
// tag wrap, illegal drop and asynchronous mid-operation reset.
module tb_dispatch_ctrl;
    import dispatch_pkg::*;

    localparam logic [31:0] ADD  = 32'h005201B3;
    localparam logic [31:0] SW   = 32'h00542423;
    localparam logic [31:0] ADDI = 32'hFFF30293;
    localparam logic [31:0] BNE  = 32'h00209863;
    localparam logic [31:0] ILL  = 32'h00000000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dispatch_ctrl_if bus ();

    dispatch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic decode_data mk(input logic [31:0] ins,
                                      input logic [31:0] pc);
        decode_data d;
        d.pc     = pc;
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.rd     = ins[11:7];
        d.imm    = {{20{ins[31]}}, ins[31:20]};
        d.ALUOp  = 4'h0;
        d.Opcode = ins[6:0];
        return d;
    endfunction

    task automatic idle();
        bus.dec_valid    = 1'b0;
        bus.dec_data     = '0;
        bus.flush        = 1'b0;
        bus.rob_ready    = 1'b1;
        bus.rs_alu_ready = 1'b1;
        bus.rs_lsu_ready = 1'b1;
        bus.rs_br_ready  = 1'b1;
        bus.fl_empty     = 1'b0;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        bus.dec_valid = 1'b1;
        bus.dec_data  = mk(ins, pc);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
        chk("rst_dec_ready", 32'(bus.dec_ready), 32'd1);
        chk("rst_tag", 32'(bus.disp_tag), 32'd0);
        chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
        chk("rst_we", 32'({bus.alu_we, bus.lsu_we, bus.br_we, bus.fl_pop}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ADD dispatch, then SW with an empty free list
        push(ADD, 32'h8);
        #1;
        chk("add_acc_ready", 32'(bus.dec_ready), 32'd1);
        chk("add_no_bypass", 32'(bus.disp_valid), 32'd0);
        @(negedge clk);
        bus.dec_valid = 1'b0;
        #1;
        chk("add_valid", 32'(bus.disp_valid), 32'd1);
        chk("add_fu", 32'(bus.disp_fu), 32'd0);
        chk("add_alu_we", 32'(bus.alu_we), 32'd1);
        chk("add_lsu_we", 32'(bus.lsu_we), 32'd0);
        chk("add_fl_pop", 32'(bus.fl_pop), 32'd1);
        chk("add_tag", 32'(bus.disp_tag), 32'd0);
        chk("add_rd", 32'(bus.disp_data.rd), 32'd3);
        chk("add_pc", bus.disp_data.pc, 32'h8);
        @(negedge clk);
        bus.fl_empty = 1'b1;
        push(SW, 32'hC);
        @(negedge clk);
        bus.dec_valid = 1'b0;
        #1;
        chk("sw_valid", 32'(bus.disp_valid), 32'd1);
        chk("sw_fu", 32'(bus.disp_fu), 32'd1);
        chk("sw_lsu_we", 32'(bus.lsu_we), 32'd1);
        chk("sw_alu_we", 32'(bus.alu_we), 32'd0);
        chk("sw_fl_pop", 32'(bus.fl_pop), 32'd0);
        chk("sw_tag", 32'(bus.disp_tag), 32'd1);
        @(negedge clk);

        // ALU backpressure with three ADDIs
        do_reset();
        bus.rs_alu_ready = 1'b0;
        push(ADDI, 32'h100);
        #1;
        chk("bp_rdy0", 32'(bus.dec_ready), 32'd1);
        @(negedge clk);
        push(ADDI, 32'h104);
        #1;
        chk("bp_rdy1", 32'(bus.dec_ready), 32'd1);
        chk("bp_stall_v1", 32'(bus.disp_valid), 32'd0);
        chk("bp_stall0", 32'(bus.stall_cycles), 32'd0);
        @(negedge clk);
        push(ADDI, 32'h108);
        #1;
        chk("bp_full_rdy", 32'(bus.dec_ready), 32'd0);
        chk("bp_stall1", 32'(bus.stall_cycles), 32'd1);
        @(negedge clk);
        #1;
        chk("bp_stall2", 32'(bus.stall_cycles), 32'd2);
        @(negedge clk);
        bus.rs_alu_ready = 1'b1;
        #1;
        chk("bp_d0_valid", 32'(bus.disp_valid), 32'd1);
        chk("bp_d0_tag", 32'(bus.disp_tag), 32'd0);
        chk("bp_d0_pc", bus.disp_data.pc, 32'h100);
        chk("bp_full_fire_rdy", 32'(bus.dec_ready), 32'd0);
        chk("bp_stall3", 32'(bus.stall_cycles), 32'd3);
        @(negedge clk);
        #1;
        chk("bp_rdy_back", 32'(bus.dec_ready), 32'd1);
        chk("bp_d1_valid", 32'(bus.disp_valid), 32'd1);
        chk("bp_d1_tag", 32'(bus.disp_tag), 32'd1);
        chk("bp_d1_pc", bus.disp_data.pc, 32'h104);
        @(negedge clk);
        bus.dec_valid = 1'b0;
        #1;
        chk("bp_d2_valid", 32'(bus.disp_valid), 32'd1);
        chk("bp_d2_tag", 32'(bus.disp_tag), 32'd2);
        chk("bp_d2_pc", bus.disp_data.pc, 32'h108);
        chk("bp_drain_rdy", 32'(bus.dec_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("bp_empty_v", 32'(bus.disp_valid), 32'd0);
        chk("bp_stall_hold", 32'(bus.stall_cycles), 32'd3);
        @(negedge clk);

        // Flush with the FIFO full
        do_reset();
        bus.rs_alu_ready = 1'b0;
        push(ADD, 32'h200);
        @(negedge clk);
        push(ADD, 32'h204);
        @(negedge clk);
        bus.dec_valid    = 1'b0;
        bus.rs_alu_ready = 1'b1;
        bus.flush        = 1'b1;
        #1;
        chk("fl_disp_v", 32'(bus.disp_valid), 32'd0);
        chk("fl_dec_rdy", 32'(bus.dec_ready), 32'd0);
        chk("fl_we", 32'({bus.alu_we, bus.fl_pop}), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("fl_after_rdy", 32'(bus.dec_ready), 32'd1);
        chk("fl_after_v", 32'(bus.disp_valid), 32'd0);
        chk("fl_tag", 32'(bus.disp_tag), 32'd0);
        chk("fl_stall", 32'(bus.stall_cycles), 32'd1);
        push(ADD, 32'h208);
        @(negedge clk);
        bus.dec_valid = 1'b0;
        #1;
        chk("fl_redisp_v", 32'(bus.disp_valid), 32'd1);
        chk("fl_redisp_pc", bus.disp_data.pc, 32'h208);
        chk("fl_redisp_tag", 32'(bus.disp_tag), 32'd0);
        @(negedge clk);

        // 17 back-to-back ADDs wrap the tag, then an illegal drop
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < 17) push(ADD, 32'(i * 4));
            else bus.dec_valid = 1'b0;
            #1;
            if (i > 0) begin
                chk("wrap_valid", 32'(bus.disp_valid), 32'd1);
                chk("wrap_tag", 32'(bus.disp_tag), 32'((i - 1) % 16));
            end
            @(negedge clk);
        end
        push(ILL, 32'h300);
        @(negedge clk);
        bus.dec_valid = 1'b0;
        #1;
        chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
        chk("ill_disp_v", 32'(bus.disp_valid), 32'd0);
        chk("ill_we", 32'({bus.alu_we, bus.lsu_we, bus.br_we}), 32'd0);
        chk("ill_tag", 32'(bus.disp_tag), 32'd1);
        @(negedge clk);
        #1;
        chk("ill_one_cycle", 32'(bus.illegal_op), 32'd0);
        chk("ill_tag_hold", 32'(bus.disp_tag), 32'd1);
        chk("ill_no_stall", 32'(bus.stall_cycles), 32'd0);
        @(negedge clk);

        // Asynchronous reset with two BNEs buffered
        do_reset();
        bus.rs_br_ready = 1'b0;
        push(ADD, 32'h400);
        @(negedge clk);
        push(BNE, 32'h404);
        #1;
        chk("mr_add_tag", 32'(bus.disp_tag), 32'd0);
        @(negedge clk);
        push(BNE, 32'h408);
        @(negedge clk);
        bus.dec_valid = 1'b0;
        #1;
        chk("mr_full_rdy", 32'(bus.dec_ready), 32'd0);
        chk("mr_pre_tag", 32'(bus.disp_tag), 32'd1);
        chk("mr_pre_stall", 32'(bus.stall_cycles), 32'd1);
        chk("mr_head_fu", 32'(bus.disp_fu), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("mr_tag", 32'(bus.disp_tag), 32'd0);
        chk("mr_stall", 32'(bus.stall_cycles), 32'd0);
        chk("mr_rdy", 32'(bus.dec_ready), 32'd1);
        bus.rs_br_ready = 1'b1;
        #1;
        chk("mr_disp_v", 32'(bus.disp_valid), 32'd0);
        chk("mr_br_we", 32'(bus.br_we), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        push(ADD, 32'h40);
        #1;
        chk("mr_rel_v", 32'(bus.disp_valid), 32'd0);
        @(negedge clk);
        bus.dec_valid = 1'b0;
        #1;
        chk("mr_first_v", 32'(bus.disp_valid), 32'd1);
        chk("mr_first_tag", 32'(bus.disp_tag), 32'd0);
        chk("mr_first_pc", bus.disp_data.pc, 32'h40);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Dispatch controller between `decode` and the rename/issue back end. It buffers decoded instructions in a 2-entry FIFO, classifies each by opcode into ALU, LSU or branch, and dispatches one per cycle only when the ROB, the target reservation station and, if needed, the free list can all accept it. It also assigns sequential ROB tags, flushes on mispredict and counts structural stall cycles.

## Interface
- `ROB_IDX_W`, default 4: width of the dispatch tag; the tag wraps at 2^ROB_IDX_W.
- `STALL_W`, default 16: width of the stall counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decoded instruction valid (driven by `decode` `valid_out`).
- `dec_ready`  out  1  FIFO can accept (drives `decode` `ready_out`).
- `dec_data`  in  decode_data  decoded fields: pc, rs1, rs2, rd, imm, ALUOp, Opcode.
- `flush`  in  1  mispredict flush, single-cycle pulse.
- `rob_ready`  in  1  ROB has at least 1 free entry.
- `rs_alu_ready`, `rs_lsu_ready`, `rs_br_ready`  in  1 each  the named reservation station has a free slot.
- `fl_empty`  in  1  physical-register free list is empty.
- `disp_valid`  out  1  dispatch fires this cycle.
- `disp_data`  out  decode_data  FIFO head entry.
- `disp_fu`  out  2  destination unit: 00 ALU, 01 LSU, 10 BR.
- `disp_tag`  out  ROB_IDX_W  sequence tag of the dispatched instruction.
- `alu_we`, `lsu_we`, `br_we`  out  1 each  one-hot reservation-station write; equals `disp_valid` gated by `disp_fu`.
- `fl_pop`  out  1  pops a physical register; asserted when `disp_valid` and the head needs a destination.
- `illegal_op`  out  1  1-cycle pulse when an unrecognised opcode is dropped.
- `stall_cycles`  out  STALL_W  saturating structural-stall counter.

## Operation
- **FIFO.** 2 entries, head/tail pointers plus a `count` register in the range 0..2.
  - `dec_ready = (count != 2) && !flush`.
  - Enqueue on `dec_valid && dec_ready`.
- **Classification** of the head entry by Opcode:
  - ALU: 0110011, 0010011, 0110111, 0010111.
  - LSU: 0000011, 0100011.
  - BR: 1100011, 1101111, 1100111.
  - Any other opcode is illegal.
- **needs_preg** = `rd != 0` and Opcode is not 0100011 or 1100011.
- **Legal head** fires when: head valid && !flush && rob_ready && the selected rs_*_ready && (!needs_preg || !fl_empty).
  - On fire: `disp_valid = 1`, dequeue, and `disp_tag` increments by 1 (modulo 2^ROB_IDX_W).
- **Illegal head** (and !flush): dequeued the same cycle with `illegal_op = 1`.
  - `disp_valid = 0`, the tag does not advance, and no resource is checked.
- **Outputs are combinational from FIFO state and the ready inputs.** There is no combinational path from `dec_valid` to `disp_valid`.
- **Stall counter.** `stall_cycles` increments when a legal head is valid, there is no flush, and it does not fire. It saturates at the all-ones value.
- **Flush** has priority over everything else:
  - That cycle: `disp_valid`, `fl_pop`, the `*_we` outputs and `illegal_op` are all 0, and no enqueue occurs.
  - At the edge: `count` and the pointers clear to 0.
  - `disp_tag` and `stall_cycles` are unchanged.
- **Simultaneous enqueue and dequeue:** `count` is unchanged, and the pointers advance modulo 2.

## Timing
- Reset values (asynchronous, while `reset` = 0):
  - `count` = 0, pointers = 0, `disp_tag` = 0, `stall_cycles` = 0.
  - `disp_valid`, `fl_pop`, `alu_we`, `lsu_we`, `br_we`, `illegal_op` = 0.
  - `dec_ready` = 1, unless `flush` is high.
- Reset asserted mid-operation discards all buffered entries immediately. No dispatch occurs in the cycle reset is released.
- Latency: an instruction accepted at edge N can dispatch in cycle N+1 at the earliest.
- Throughput: 1 instruction per cycle sustained with `count` = 1.
- `dec_ready` stays 1 while the head drains every cycle.
- When `count` = 2 and the head fires, `dec_ready` is still 0 that cycle and rises the following cycle. There is no same-cycle bypass when full.
- `disp_data`, `disp_fu` and `disp_tag` are stable whenever the head is valid. They are don't-care when `count` = 0.
- Tag wrap: 2^ROB_IDX_W − 1 → 0 on the next fire.

## Test plan
- **ADD dispatch.** Push 0x005201B3 at pc 0x8 with all readies 1 and `fl_empty` = 0.
  - Next cycle: `disp_valid` = 1, `disp_fu` = 00, `alu_we` = 1, `fl_pop` = 1, `disp_tag` = 0, `disp_data.rd` = 3.
- **SW with empty free list.** Push 0x00542423 with `fl_empty` = 1.
  - Dispatches with `disp_fu` = 01, `lsu_we` = 1, `fl_pop` = 0.
- **ALU backpressure.** Hold `rs_alu_ready` = 0 and push 3 ADDIs (0xFFF30293).
  - After 2 accepts, `dec_ready` = 0 and `stall_cycles` increments by 1 per cycle.
  - Release `rs_alu_ready`: the 3 ADDIs dispatch with tags 0, 1, 2 in consecutive cycles.
- **Flush.** With `count` = 2, pulse `flush`.
  - Same cycle: `disp_valid` = 0 and `dec_ready` = 0.
  - Next cycle: `count` = 0, `dec_ready` = 1, and the tag is unchanged.
- **Tag wrap and illegal drop.** Dispatch 17 ADDs with ROB_IDX_W = 4: the 17th has `disp_tag` = 0.
  - Then push 0x00000000: `illegal_op` pulses for 1 cycle, `disp_valid` = 0, and the tag stays 1.
- **Mid-operation reset.** Drop `reset` low while `count` = 2 and BNE 0x00209863 is at the head.
  - All outputs return to their reset values asynchronously.
  - After release, the first pushed instruction dispatches with tag 0.
